// File: rtl/bb_uart_rx.sv
// bb_uart_rx: 8N1 UART receiver for the ispMACH 4256ZE breakout board, clocked at OVS x baud.
// Define BB_UART_RX_MAJORITY_EN to take each decision on a 3-sample majority vote of the line.
module bb_uart_rx #(
    parameter int OVS = 16  // ticks per bit, 8 or 16
) (
    input  logic       bdclk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rxreg,
    output logic       rxrdy,
    input  logic       rxack,
    output logic       rxbsy,
    output logic       ferr,
    output logic       oerr
);

    typedef enum logic [2:0] {
        WAITHI,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [3:0] CNT_HALF = 4'(OVS / 2 - 1);
    localparam logic [3:0] CNT_FULL = 4'(OVS - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bitn_q, bitn_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] sync_q;
    logic       rxs;
    logic       smp;

    logic [7:0] rxreg_q, rxreg_d;
    logic       rxrdy_q, rxrdy_d;
    logic       rxbsy_q, rxbsy_d;
    logic       ferr_q, ferr_d;
    logic       oerr_q, oerr_d;

    logic       stop_sample;
    logic       good_frame;
    logic       bad_frame;

    // NOTE: every flop below is written with <= so all registers update from the same old values.
    always_ff @(posedge bdclk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxs = sync_q[1];

`ifdef BB_UART_RX_MAJORITY_EN
    // Two older copies of rxs; together with rxs itself they form the three-sample window.
    logic [1:0] hist_q;

    always_ff @(posedge bdclk) begin
        if (rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign smp = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign smp = rxs;
`endif

    // State register, datapath and registered outputs.
    always_ff @(posedge bdclk) begin
        if (rst) begin
            state_q <= WAITHI;
            cnt_q   <= 4'd0;
            bitn_q  <= 3'd0;
            shreg_q <= 8'h00;
            rxreg_q <= 8'h00;
            rxrdy_q <= 1'b0;
            rxbsy_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
            rxreg_q <= rxreg_d;
            rxrdy_q <= rxrdy_d;
            rxbsy_q <= rxbsy_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shreg_d = shreg_q;

        case (state_q)
            WAITHI: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = 4'd0;
                end
            end
            START: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_HALF) begin
                    if (!smp) begin
                        state_d = DATA;
                        cnt_d   = 4'd0;
                        bitn_d  = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_FULL) begin
                    shreg_d = {smp, shreg_q[7:1]};
                    cnt_d   = 4'd0;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = 4'd0;
                    // A low stop bit may be the start of a break; wait for the line to recover.
                    state_d = smp ? IDLE : WAITHI;
                end
            end
            default: begin
                state_d = WAITHI;
            end
        endcase
    end

    assign stop_sample = (state_q == STOP) && (cnt_q == CNT_FULL);
    assign good_frame  = stop_sample && smp;
    assign bad_frame   = stop_sample && !smp;

    // Output logic: delivery, overrun, framing error and acknowledge.
    always_comb begin
        rxreg_d = rxreg_q;
        rxrdy_d = rxrdy_q;
        ferr_d  = ferr_q;
        oerr_d  = oerr_q;
        rxbsy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);

        if (good_frame) begin
            ferr_d = 1'b0;
            if (!rxrdy_q || rxack) begin
                rxreg_d = shreg_q;
                rxrdy_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end else if (bad_frame) begin
            ferr_d = 1'b1;
        end else if (rxrdy_q && rxack) begin
            rxrdy_d = 1'b0;
            oerr_d  = 1'b0;
        end
    end

    assign rxreg = rxreg_q;
    assign rxrdy = rxrdy_q;
    assign rxbsy = rxbsy_q;
    assign ferr  = ferr_q;
    assign oerr  = oerr_q;

endmodule

// File: doc/bb_uart_rx.md
# bb_uart_rx

UART receiver for the ispMACH 4256ZE Breakout Board: 8N1 frames on `rxd`, LSB first, deserialised into a parallel byte. It is the receive half of the board UART, paired with the existing transmitter. It runs from an oversampling clock at OVS × baud rate, for example 153.6 kHz for 9600 Bd at OVS=16. Received bytes go to the user logic through a level `rxrdy`/`rxack` handshake, with sticky framing and overrun flags.

## Interface
- `OVS`, default 16: oversampling factor, bdclk ticks per bit. Legal values are 8 and 16. The tick counter is 4 bits wide.
- `bdclk` input, 1 bit: oversampling clock at OVS × baud. Single clock domain.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `rxd` input, 1 bit: serial line. Asynchronous to `bdclk`. Idle level is 1.
- `rxreg` output, 8 bits: last good received byte.
- `rxrdy` output, 1 bit: `rxreg` holds an unacknowledged byte.
- `rxack` input, 1 bit: user has consumed `rxreg`. Sampled only while `rxrdy`=1.
- `rxbsy` output, 1 bit: a frame is in progress (states START, DATA, STOP).
- `ferr` output, 1 bit: framing error. Sticky.
- `oerr` output, 1 bit: overrun. Sticky.

## Operation
- **Synchronizer.** `rxd` passes through a 2-flop synchronizer; its output is `rxs`. Both flops reset to 0.
- **Sample value.** `smp` is the value used at every decision point.
  - By default, `smp = rxs`.
  - See Configuration for the majority-vote variant.
- **Counters.**
  - `cnt` is 4 bits. It counts ticks within a bit and wraps only by explicit clear.
  - `bitn` is 3 bits. It indexes data bits 0..7.
- **State machine.** All transitions occur on `posedge bdclk`.
  - WAITHI: go to IDLE when `rxs`=1. This is the reset state, so the receiver never starts inside a frame that was already running at reset.
  - IDLE: when `rxs`=0, go to START and set `cnt`=0.
  - START: increment `cnt` each tick. When `cnt`=OVS/2−1, check `smp`:
    - `smp`=0: valid start bit. Go to DATA with `cnt`=0, `bitn`=0.
    - `smp`=1: glitch. Return to IDLE with no flag change.
  - DATA: increment `cnt` each tick. When `cnt`=OVS−1:
    - Shift `smp` into the MSB of the shift register (LSB-first reception).
    - Set `cnt`=0 and increment `bitn`.
    - After bit 7, go to STOP.
  - STOP: increment `cnt` each tick. When `cnt`=OVS−1, check `smp`:
    - `smp`=1: deliver the byte (see below) and go to IDLE.
    - `smp`=0: set `ferr`=1, discard the byte, do not touch `rxrdy`, and go to WAITHI. A break is absorbed here.
- **Delivery of a good frame.**
  - If `rxrdy`=0, or if `rxrdy`=1 and `rxack`=1 in the same cycle: `rxreg` ← shift register, `rxrdy`=1, `ferr`=0.
  - If `rxrdy`=1 and `rxack`=0: the new byte is dropped, `rxreg` is unchanged, `oerr`=1 and `ferr`=0.
- **Acknowledge.** `rxack`=1 while `rxrdy`=1, with no delivery in that cycle, sets `rxrdy`=0 and `oerr`=0.
  - `rxack` while `rxrdy`=0 is ignored.
- **Reset values.**
  - Outputs: `rxreg`=8'h00, `rxrdy`=0, `rxbsy`=0, `ferr`=0, `oerr`=0.
  - Internal: state=WAITHI, `cnt`=0, `bitn`=0.
- **Reset mid-frame.** The partial byte is discarded. The receiver waits in WAITHI until the line returns high.

## Timing
- **Edge numbering.** Edge 0 is the first `bdclk` edge at which `rxd`=0 is captured. Add ±1 edge for asynchronous phase.
  - `rxs`=0 appears after edge 1.
  - START is entered at edge 2.
  - DATA is entered at edge 2+OVS/2.
- **Sample points.** Data bit k is sampled at edge 2+OVS/2+(k+1)·OVS. The stop bit is sampled at edge 2+OVS/2+9·OVS.
- **Latency.** `rxrdy` is high after edge 2+OVS/2+9·OVS, which is edge 154 for OVS=16. `rxbsy` falls on the same edge.
- **Outputs.** All outputs are registered. `rxreg` is stable for the whole time `rxrdy`=1.
- **Back-to-back frames.** The receiver returns to IDLE mid-stop-bit. It therefore accepts a new start edge at a baud mismatch of up to about ±4%.

## Configuration
- Macro: `BB_UART_RX_MAJORITY_EN`.
- When defined:
  - A 3-bit history holds the last three `rxs` values.
  - `smp` = majority(`rxs`[t], `rxs`[t−1], `rxs`[t−2]).
  - The vote applies to start validation, data bits and the stop bit.
  - IDLE edge detection still uses raw `rxs`.
  - The sample point moves back by about 1 tick; latency is unchanged.
- When not defined: `smp = rxs`, and the history register is not present.

## Test plan
- **Single byte.** Reset; `rxd`=1 for 20 ticks; send 8'hA5 at OVS=16, 8N1. Expect `rxrdy`↑ 154±1 edges after the start edge, `rxreg`=8'hA5, `ferr`=`oerr`=0, `rxbsy` high for the whole frame. Pulse `rxack` for 1 cycle; expect `rxrdy`=0 next cycle.
- **Glitch rejection.** Drive `rxd`=0 for 3 ticks, then 1. Expect a return to IDLE, `rxbsy` high for at most 8 ticks, and no `rxrdy`, `ferr` or `oerr`. Then send 8'h3C; expect it to be received correctly.
- **Framing error.** Send 8'h55 with the stop bit forced to 0 and hold `rxd`=0 for 40 more ticks. Expect `ferr`=1, `rxrdy` unchanged, no new frame until `rxd`=1. Then send 8'h12; expect `rxreg`=8'h12 and `ferr`=0.
- **Overrun.** Send 8'h01 and 8'h02 without `rxack`. Expect `rxreg`=8'h01, `oerr`=1. On `rxack`, expect `rxrdy`=0 and `oerr`=0.
- **Simultaneous delivery and acknowledge.** Assert `rxack` exactly on the stop-sample edge of the second byte 8'h02. Expect `rxreg`=8'h02, `rxrdy` staying 1, `oerr`=0.
- **Reset mid-frame.** Assert `rst` during bit 4 with `rxd` held 0. Expect all outputs at reset values and no reception until `rxd`=1. Then send 8'hFF; expect correct reception.
  - With `BB_UART_RX_MAJORITY_EN` defined, add a 1-tick 0-glitch at the data bit 3 mid-sample; expect the byte still received correctly.
